// File: rtl/wb_write_queue_if.sv
// Bundle of write-back request, forwarding and register-file write signals
// shared between the write queue and the pipeline around it.
interface wb_write_queue_if;
  logic        AluValid;
  logic [4:0]  AluAddr;
  logic [31:0] AluData;
  logic        MdValid;
  logic        MdReady;
  logic [4:0]  MdAddr;
  logic [31:0] MdData;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic        RsHit;
  logic        RtHit;
  logic [31:0] RsFwdData;
  logic [31:0] RtFwdData;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        RegWrite;

  modport master (
    output AluValid, AluAddr, AluData, MdValid, MdAddr, MdData, RsAddr, RtAddr,
    input  MdReady, RsHit, RtHit, RsFwdData, RtFwdData, WriteAddr, WriteData, RegWrite
  );

  modport slave (
    input  AluValid, AluAddr, AluData, MdValid, MdAddr, MdData, RsAddr, RtAddr,
    output MdReady, RsHit, RtHit, RsFwdData, RtFwdData, WriteAddr, WriteData, RegWrite
  );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back queue: merges ALU and MDU results in program order, issues one
// registered register-file write per cycle and forwards still-pending data.
module wb_write_queue #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  wb_write_queue_if.slave wb,
  output logic [PW-1:0]  Pending,
  output logic           Idle
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbEntry_t;

  wbEntry_t       queue [DEPTH];
  wbEntry_t       nextQueue [DEPTH];
  wbEntry_t       cand [DEPTH+2];
  logic [PW-1:0]  pendingCnt;
  logic [PW-1:0]  nextPending;
  logic [4:0]     outAddr;
  logic [31:0]    outData;
  logic           outValid;
  logic           mdReady;
  logic           mdAccept;
  logic           aluAccept;
  int             candCount;

  // Handshake and zero-address filtering; MDU readiness looks only at registered occupancy.
  always_comb begin
    mdReady   = !reset && (pendingCnt < PW'(DEPTH));
    mdAccept  = wb.MdValid && mdReady && (wb.MdAddr != 5'd0);
    aluAccept = wb.AluValid && (wb.AluAddr != 5'd0);
  end

  // Ordered candidate list: queued entries oldest first, then MDU, then ALU.
  always_comb begin
    candCount = int'(pendingCnt) + int'(mdAccept) + int'(aluAccept);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cand[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(pendingCnt)) cand[i] = queue[i];
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (mdAccept && (i == int'(pendingCnt))) cand[i] = '{wb.MdAddr, wb.MdData};
      if (aluAccept && (i == int'(pendingCnt) + int'(mdAccept))) cand[i] = '{wb.AluAddr, wb.AluData};
    end
    for (int i = 0; i < DEPTH; i++) begin
      nextQueue[i] = cand[i+1];
    end
    nextPending = (candCount > 0) ? PW'(candCount - 1) : '0;
  end

  // Head candidate goes to the output register, the rest shift into the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid   <= 1'b0;
      outAddr    <= '0;
      outData    <= '0;
      pendingCnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= '0;
      end
    end else begin
      outValid   <= (candCount > 0);
      if (candCount > 0) begin
        outAddr <= cand[0].addr;
        outData <= cand[0].data;
      end
      pendingCnt <= nextPending;
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= nextQueue[i];
      end
    end
  end

  // Forwarding search, oldest to youngest so the youngest match ends up winning.
  always_comb begin
    wb.RsHit     = 1'b0;
    wb.RsFwdData = '0;
    wb.RtHit     = 1'b0;
    wb.RtFwdData = '0;
    if (wb.RsAddr != 5'd0) begin
      if (outValid && (outAddr == wb.RsAddr)) begin
        wb.RsHit     = 1'b1;
        wb.RsFwdData = outData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((i < int'(pendingCnt)) && (queue[i].addr == wb.RsAddr)) begin
          wb.RsHit     = 1'b1;
          wb.RsFwdData = queue[i].data;
        end
      end
    end
    if (wb.RtAddr != 5'd0) begin
      if (outValid && (outAddr == wb.RtAddr)) begin
        wb.RtHit     = 1'b1;
        wb.RtFwdData = outData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((i < int'(pendingCnt)) && (queue[i].addr == wb.RtAddr)) begin
          wb.RtHit     = 1'b1;
          wb.RtFwdData = queue[i].data;
        end
      end
    end
  end

  // Output port drive and status flags.
  always_comb begin
    wb.MdReady   = mdReady;
    wb.WriteAddr = outAddr;
    wb.WriteData = outData;
    wb.RegWrite  = outValid;
    Pending      = pendingCnt;
    Idle         = (pendingCnt == '0) && !outValid;
  end

endmodule
